flux_fifo: RTL and testbench

//  Multi-flux channel buffer between an actor's write port (din/write/full) and a downstream

---
 rtl/fifo_pkg.sv | 9 +
 rtl/fifo_lane.sv | 60 ++++++
 rtl/flux_fifo.sv | 97 +++++++++
 tb/tb_flux_fifo.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared definitions for the flux FIFO and the actor wrappers that drive it.
// The tag width lives here so that every producer agrees on the din layout.
package fifo_pkg;

    function automatic int tag_w(input int flux);
        return (flux > 1) ? $clog2(flux) : 0;
    endfunction

endpackage

// File: rtl/fifo_lane.sv
// One circular queue: storage, read/write pointers, occupancy count and status decode.
// The lane refuses pushes when full and pops when empty, judged on the pre-edge count.
module fifo_lane
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 4,
    parameter int DEPTH      = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic                  pop,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  full,
    output logic                  empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      rd_ptr;
    logic [PTR_W-1:0]      wr_ptr;
    logic [CNT_W-1:0]      count;
    logic                  push_ok;
    logic                  pop_ok;

    // Explicit wrap so DEPTH need not be a power of two.
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= next_ptr(wr_ptr);
            if (pop_ok)  rd_ptr <= next_ptr(rd_ptr);
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/flux_fifo.sv
// Multi-flux channel buffer: FLUX independent queues selected by the din tag, one shared
// registered read port with lowest-index-wins arbitration across the read strobes.
module flux_fifo
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 4,
    parameter int FLUX       = 1,
    parameter int DEPTH      = 4,
    localparam int TAG_W     = tag_w(FLUX),
    localparam int DW        = DATA_WIDTH + TAG_W
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [DW-1:0]   din,
    input  logic            write,
    output logic [FLUX-1:0] full,
    output logic [DW-1:0]   dout,
    input  logic [FLUX-1:0] read,
    output logic [FLUX-1:0] empty
);

    logic [FLUX-1:0] push;
    logic [FLUX-1:0] pop;
    logic [DW-1:0]   word [FLUX];
    logic [DW-1:0]   sel_word;
    logic            sel_vld;
    logic            sel_empty;
    logic            pop_ok;

    generate
        if (FLUX == 1) begin : g_single
            assign push = write;
        end else begin : g_multi
            logic [TAG_W-1:0] tag;
            assign tag = din[DATA_WIDTH +: TAG_W];
            // Tags at or beyond FLUX match no lane, so such writes vanish.
            always_comb begin
                push = '0;
                for (int f = 0; f < FLUX; f++) begin
                    if (write && (tag == TAG_W'(f))) push[f] = 1'b1;
                end
            end
        end
    endgenerate

    for (genvar g = 0; g < FLUX; g++) begin : g_lane
        logic [DATA_WIDTH-1:0] rdata;

        fifo_lane #(
            .DATA_WIDTH(DATA_WIDTH),
            .DEPTH     (DEPTH)
        ) u_lane (
            .clk  (clk),
            .rst  (rst),
            .push (push[g]),
            .pop  (pop[g]),
            .wdata(din[DATA_WIDTH-1:0]),
            .rdata(rdata),
            .full (full[g]),
            .empty(empty[g])
        );

        if (FLUX == 1) begin : g_word
            assign word[g] = rdata;
        end else begin : g_word
            assign word[g] = {TAG_W'(g), rdata};
        end
    end

    // Scan high to low so the lowest requesting index is the one left standing.
    always_comb begin
        pop       = '0;
        sel_vld   = 1'b0;
        sel_empty = 1'b1;
        sel_word  = '0;
        for (int f = FLUX - 1; f >= 0; f--) begin
            if (read[f]) begin
                pop       = '0;
                pop[f]    = 1'b1;
                sel_vld   = 1'b1;
                sel_empty = empty[f];
                sel_word  = word[f];
            end
        end
    end

    assign pop_ok = sel_vld & ~sel_empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout <= '0;
        end else if (pop_ok) begin
            dout <= sel_word;
        end
    end

endmodule

// File: tb/tb_flux_fifo.sv
// Bench for flux_fifo: directed scenarios plus random traffic against queue-based models,
// one instance at FLUX=2/DEPTH=4 and one at FLUX=1/DEPTH=3.
module tb_flux_fifo;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [4:0] din_a;
    logic       write_a;
    logic [1:0] full_a;
    logic [4:0] dout_a;
    logic [1:0] read_a;
    logic [1:0] empty_a;
    logic [3:0] din_b;
    logic       write_b;
    logic       full_b;
    logic [3:0] dout_b;
    logic       read_b;
    logic       empty_b;

    flux_fifo #(.DATA_WIDTH(4), .FLUX(2), .DEPTH(4)) dut_a (
        .clk(clk), .rst(rst), .din(din_a), .write(write_a), .full(full_a),
        .dout(dout_a), .read(read_a), .empty(empty_a)
    );

    flux_fifo #(.DATA_WIDTH(4), .FLUX(1), .DEPTH(3)) dut_b (
        .clk(clk), .rst(rst), .din(din_b), .write(write_b), .full(full_b),
        .dout(dout_b), .read(read_b), .empty(empty_b)
    );

    int checks   = 0;
    int failures = 0;

    logic [3:0] qa0[$];
    logic [3:0] qa1[$];
    logic [3:0] qb[$];
    logic [4:0] exp_a;
    logic [3:0] exp_b;

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    task automatic check_a(input string name);
        chk({name, ".dout"},  32'(dout_a),  32'(exp_a));
        chk({name, ".empty"}, 32'(empty_a), 32'({qa1.size() == 0, qa0.size() == 0}));
        chk({name, ".full"},  32'(full_a),  32'({qa1.size() == 4, qa0.size() == 4}));
    endtask

    task automatic check_b(input string name);
        chk({name, ".dout"},  32'(dout_b),  32'(exp_b));
        chk({name, ".empty"}, 32'(empty_b), 32'(qb.size() == 0));
        chk({name, ".full"},  32'(full_b),  32'(qb.size() == 3));
    endtask

    task automatic step_a(input bit w, input logic [4:0] d, input logic [1:0] r, input string name);
        int  s0, s1, pf;
        bit  wacc, pacc;
        @(negedge clk);
        write_a = w;
        din_a   = d;
        read_a  = r;
        s0   = qa0.size();
        s1   = qa1.size();
        wacc = w && ((d[4] == 1'b0) ? (s0 < 4) : (s1 < 4));
        pf   = r[0] ? 0 : (r[1] ? 1 : -1);
        pacc = (pf == 0 && s0 > 0) || (pf == 1 && s1 > 0);
        @(posedge clk);
        #1;
        if (pacc) begin
            if (pf == 0) exp_a = {1'b0, qa0.pop_front()};
            else         exp_a = {1'b1, qa1.pop_front()};
        end
        if (wacc) begin
            if (d[4]) qa1.push_back(d[3:0]);
            else      qa0.push_back(d[3:0]);
        end
        write_a = 1'b0;
        read_a  = 2'b00;
        check_a(name);
    endtask

    task automatic step_b(input bit w, input logic [3:0] d, input bit r, input string name);
        bit wacc, pacc;
        @(negedge clk);
        write_b = w;
        din_b   = d;
        read_b  = r;
        wacc = w && (qb.size() < 3);
        pacc = r && (qb.size() > 0);
        @(posedge clk);
        #1;
        if (pacc) exp_b = qb.pop_front();
        if (wacc) qb.push_back(d);
        write_b = 1'b0;
        read_b  = 1'b0;
        check_b(name);
    endtask

    initial begin
        logic [3:0] va, vb, vc;
        rst     = 1'b1;
        din_a   = '0;
        write_a = 1'b0;
        read_a  = '0;
        din_b   = '0;
        write_b = 1'b0;
        read_b  = 1'b0;
        exp_a   = '0;
        exp_b   = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Reset state held over idle cycles
        for (int i = 0; i < 10; i++) step_a(1'b0, 5'h0, 2'b00, "s1.idle");
        check_b("s1.idle_b");

        // Fill queue 0, drop on full, drain in order, read past empty
        for (int v = 1; v <= 4; v++) step_a(1'b1, {1'b0, 4'(v)}, 2'b00, "s2.fill");
        chk("s2.full0", 32'(full_a[0]), 32'd1);
        step_a(1'b1, 5'h05, 2'b00, "s2.drop");
        for (int v = 1; v <= 4; v++) begin
            step_a(1'b0, 5'h0, 2'b01, "s2.pop");
            chk("s2.pop_val", 32'(dout_a), 32'(v));
        end
        step_a(1'b0, 5'h0, 2'b01, "s2.pop_empty");
        chk("s2.hold", 32'(dout_a), 32'h4);

        // Interleaved fluxes and lowest-index arbitration
        va = 4'($urandom);
        vb = 4'($urandom);
        vc = 4'($urandom);
        step_a(1'b1, {1'b0, va}, 2'b00, "s3.wa");
        step_a(1'b1, {1'b1, vb}, 2'b00, "s3.wb");
        step_a(1'b1, {1'b0, vc}, 2'b00, "s3.wc");
        step_a(1'b0, 5'h0, 2'b11, "s3.r11");
        chk("s3.lowest", 32'(dout_a), 32'({1'b0, va}));
        step_a(1'b0, 5'h0, 2'b10, "s3.r10");
        chk("s3.flux1", 32'(dout_a), 32'({1'b1, vb}));
        step_a(1'b0, 5'h0, 2'b01, "s3.r01");
        chk("s3.flux0", 32'(dout_a), 32'({1'b0, vc}));

        // Steady-state push+pop on queue 0 with pointer wrap
        step_a(1'b1, {1'b0, 4'($urandom)}, 2'b00, "s4.pre");
        step_a(1'b1, {1'b0, 4'($urandom)}, 2'b00, "s4.pre");
        for (int i = 0; i < 6; i++) step_a(1'b1, {1'b0, 4'($urandom)}, 2'b01, "s4.pushpop");
        for (int i = 0; i < 3; i++) step_a(1'b0, 5'h0, 2'b01, "s4.drain");

        // Write+read on empty queue 1, then on full queue 0
        step_a(1'b1, {1'b1, 4'hA}, 2'b10, "s5.empty_wr_rd");
        chk("s5.q1_nonempty", 32'(empty_a[1]), 32'd0);
        step_a(1'b0, 5'h0, 2'b10, "s5.drain1");
        for (int i = 0; i < 4; i++) step_a(1'b1, {1'b0, 4'($urandom)}, 2'b00, "s5.fill0");
        step_a(1'b1, {1'b0, 4'hF}, 2'b01, "s5.full_wr_rd");
        chk("s5.q0_not_full", 32'(full_a[0]), 32'd0);
        for (int i = 0; i < 4; i++) step_a(1'b0, 5'h0, 2'b01, "s5.drain0");

        // Random traffic on both fluxes
        for (int i = 0; i < 300; i++)
            step_a(1'($urandom), 5'($urandom), 2'($urandom), "rnd.a");

        // Asynchronous reset in the middle of a burst
        for (int i = 0; i < 3; i++) step_a(1'b1, {1'b0, 4'($urandom)}, 2'b00, "s6.load");
        for (int i = 0; i < 2; i++) step_b(1'b1, 4'($urandom), 1'b0, "s6.load_b");
        @(negedge clk);
        write_a = 1'b1;
        din_a   = 5'h07;
        #2;
        rst = 1'b1;
        #1;
        chk("s6.async_dout",  32'(dout_a),  32'h0);
        chk("s6.async_empty", 32'(empty_a), 32'h3);
        chk("s6.async_full",  32'(full_a),  32'h0);
        chk("s6.async_b",     32'(empty_b), 32'h1);
        qa0.delete();
        qa1.delete();
        qb.delete();
        exp_a = '0;
        exp_b = '0;
        @(negedge clk);
        write_a = 1'b0;
        rst     = 1'b0;
        step_a(1'b0, 5'h0, 2'b11, "s6.after");
        step_a(1'b0, 5'h0, 2'b01, "s6.after");
        step_b(1'b0, 4'h0, 1'b1, "s6.after_b");

        // Single-flux, DEPTH=3 instance
        for (int v = 1; v <= 3; v++) step_b(1'b1, 4'(v), 1'b0, "b.fill");
        chk("b.full", 32'(full_b), 32'd1);
        step_b(1'b1, 4'h9, 1'b0, "b.drop");
        for (int v = 1; v <= 3; v++) begin
            step_b(1'b0, 4'h0, 1'b1, "b.pop");
            chk("b.pop_val", 32'(dout_b), 32'(v));
        end
        step_b(1'b0, 4'h0, 1'b1, "b.pop_empty");
        chk("b.hold", 32'(dout_b), 32'h3);
        for (int i = 0; i < 150; i++)
            step_b(1'($urandom), 4'($urandom), 1'($urandom), "rnd.b");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
